rectangle_keysched_128: RTL and testbench

- Round-key generator for the RECTANGLE-128 round-based core; sits directly upstream of the core's key input.
- Loads a 128-bit master key and produces the 26 round keys K0..K25, each 64 bits, one per valid/ready handshake.
- Evaluates the key-schedule round function on-the-fly with a single register stage; the consumer core pulls one key per round.

---
 rtl/rectangle_keysched_128_pkg.sv | 37 +++
 rtl/rectangle_sbox4.sv | 19 +
 rtl/rectangle_keysched_128.sv | 155 +++++++++++++++
 tb/tb_rectangle_keysched_128.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rectangle_keysched_128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rectangle_keysched_128_pkg
// Description : Shared constants, S-box table and FSM encoding for the
//               RECTANGLE-128 key schedule and its S-box sub-module.
//               Optional macro RECT_KEYBUF_EN adds the REPLAY state.
// Revision    : 1.0 - initial release
// ============================================================================
package rectangle_keysched_128_pkg;

    localparam int         C_NR        = 25;
    localparam logic [4:0] C_RC_INIT   = 5'h01;
    localparam int         C_KEY_W     = 128;
    localparam int         C_ROW_W     = 32;
    localparam int         C_RK_W      = 64;
    localparam int         C_SBOX_COLS = 8;

    // Nibble n of this word is S(n): S = {6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2}
    localparam logic [63:0] C_SBOX_TABLE = 64'h24F8_D30B_97E1_AC56;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
`ifdef RECT_KEYBUF_EN
        ST_DONE   = 2'd2,
        ST_REPLAY = 2'd3
`else
        ST_DONE   = 2'd2
`endif
    } ks_state_t;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        return C_SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rectangle_sbox4.sv
`default_nettype none
// ============================================================================
// Module      : rectangle_sbox4
// Description : 4-bit RECTANGLE S-box (pure combinational).
//   i_x : input nibble {row3,row2,row1,row0} of one column
//   o_y : substituted nibble, same bit positions
// Revision    : 1.0 - initial release
// ============================================================================
module rectangle_sbox4
    import rectangle_keysched_128_pkg::*;
(
    input  logic [3:0] i_x,
    output logic [3:0] o_y
);

    assign o_y = sbox_lookup(i_x);

endmodule
`default_nettype wire

// File: rtl/rectangle_keysched_128.sv
`default_nettype none
// ============================================================================
// Module      : rectangle_keysched_128
// Description : On-the-fly RECTANGLE-128 round-key generator. Loads a 128-bit
//               master key on i_start and emits K0..K(NR) one per
//               valid/ready handshake.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_start, iv_key     : load master key / restart schedule
//   i_ready             : consumer accepts ov_roundkey
//   ov_roundkey, ov_round, o_valid, o_last, o_busy : key stream outputs
//   i_replay            : reverse-order replay request (RECT_KEYBUF_EN only)
// Optional    : `define RECT_KEYBUF_EN adds a round-key buffer and REPLAY.
// Revision    : 1.0 - initial release
// ============================================================================
module rectangle_keysched_128
    import rectangle_keysched_128_pkg::*;
#(
    parameter int         NR      = C_NR,
    parameter logic [4:0] RC_INIT = C_RC_INIT
)(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [127:0]  iv_key,
    input  logic          i_ready,
    output logic [63:0]   ov_roundkey,
    output logic          o_valid,
    output logic          o_last,
    output logic [4:0]    ov_round,
    output logic          o_busy,
    input  logic          i_replay
);

    localparam logic [4:0] c_last_round = 5'(NR);

    ks_state_t          r_state, w_state_next;
    logic [3:0][31:0]   r_row, w_sb, w_row_next;
    logic [4:0]         r_rc, r_round;
    logic [7:0][3:0]    w_col_in, w_col_out;
    logic [63:0]        w_key;
    logic               w_valid, w_last, w_hs;

    // S-box layer touches only the eight rightmost columns
    for (genvar j = 0; j < C_SBOX_COLS; j++) begin : g_col
        assign w_col_in[j] = {r_row[3][j], r_row[2][j], r_row[1][j], r_row[0][j]};
        rectangle_sbox4 u_sbox (
            .i_x (w_col_in[j]),
            .o_y (w_col_out[j])
        );
    end

    always_comb begin
        w_sb = r_row;
        for (int j = 0; j < C_SBOX_COLS; j++) begin
            for (int k = 0; k < 4; k++) begin
                w_sb[k][j] = w_col_out[j][k];
            end
        end
        // Generalised Feistel row mix, round constant into row0[4:0]
        w_row_next[0] = {w_sb[0][23:0], w_sb[0][31:24]} ^ w_sb[1] ^ {27'd0, r_rc};
        w_row_next[1] = w_sb[2];
        w_row_next[2] = {w_sb[2][15:0], w_sb[2][31:16]} ^ w_sb[3];
        w_row_next[3] = w_sb[0];
    end

    assign w_key = {r_row[3][15:0], r_row[2][15:0], r_row[1][15:0], r_row[0][15:0]};

`ifdef RECT_KEYBUF_EN
    logic [63:0] r_buf [0:NR];

    // Rewriting the current slot every RUN cycle is harmless: the rows only
    // change on a handshake or a restart, so the last write is always Kr.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_RUN) begin
            r_buf[r_round] <= w_key;
        end
    end

    assign w_valid     = (r_state == ST_RUN) || (r_state == ST_REPLAY);
    assign w_last      = ((r_state == ST_RUN)    && (r_round == c_last_round)) ||
                         ((r_state == ST_REPLAY) && (r_round == 5'd0));
    assign ov_roundkey = (r_state == ST_REPLAY) ? r_buf[r_round] : w_key;
    assign o_busy      = w_valid;
`else
    logic w_unused_replay;
    assign w_unused_replay = i_replay;

    assign w_valid     = (r_state == ST_RUN);
    assign w_last      = w_valid && (r_round == c_last_round);
    assign ov_roundkey = w_key;
    assign o_busy      = w_valid;
`endif

    assign w_hs     = w_valid && i_ready;
    assign o_valid  = w_valid;
    assign o_last   = w_last;
    assign ov_round = r_round;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hs && w_last) w_state_next = ST_DONE;
                end
`ifdef RECT_KEYBUF_EN
                ST_DONE: begin
                    if (i_replay) w_state_next = ST_REPLAY;
                end
                ST_REPLAY: begin
                    if (w_hs && w_last) w_state_next = ST_DONE;
                end
`endif
                default: w_state_next = r_state;
            endcase
        end
    end

    // The final forward handshake leaves rows/round at K(NR) so a replay
    // can start from the top without extra bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row   <= '0;
            r_rc    <= RC_INIT;
            r_round <= 5'd0;
        end else if (i_start) begin
            r_row   <= iv_key;
            r_rc    <= RC_INIT;
            r_round <= 5'd0;
        end else if (w_hs && (r_state == ST_RUN) && !w_last) begin
            r_row   <= w_row_next;
            r_rc    <= {r_rc[3:0], r_rc[4] ^ r_rc[2]};
            r_round <= r_round + 5'd1;
        end
`ifdef RECT_KEYBUF_EN
        else if ((r_state == ST_DONE) && i_replay) begin
            r_round <= c_last_round;
        end else if (w_hs && (r_state == ST_REPLAY) && !w_last) begin
            r_round <= r_round - 5'd1;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_rectangle_keysched_128.sv
`default_nettype none
// ============================================================================
// Module      : tb_rectangle_keysched_128
// Description : Self-checking bench for rectangle_keysched_128 against a
//               behavioural key-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rectangle_keysched_128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         ready;
    logic [63:0]  roundkey;
    logic         valid;
    logic         last;
    logic [4:0]   round;
    logic         busy;
    logic         replay;

    int n_checks = 0;
    int n_fail   = 0;

    int sbox_tab [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};
    logic [63:0] exp_keys [0:25];

    always #5 clk = ~clk;

    rectangle_keysched_128 dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .iv_key      (key),
        .i_ready     (ready),
        .ov_roundkey (roundkey),
        .o_valid     (valid),
        .o_last      (last),
        .ov_round    (round),
        .o_busy      (busy),
        .i_replay    (replay)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference schedule computed straight from the round definition
    task automatic gen_model(input logic [127:0] mk);
        logic [31:0] r [4];
        logic [31:0] n [4];
        logic [4:0]  rc;
        logic [3:0]  nib, s;
        for (int i = 0; i < 4; i++) r[i] = mk[32*i +: 32];
        rc = 5'h01;
        for (int rnd = 0; rnd <= 25; rnd++) begin
            exp_keys[rnd] = {r[3][15:0], r[2][15:0], r[1][15:0], r[0][15:0]};
            for (int j = 0; j < 8; j++) begin
                nib = {r[3][j], r[2][j], r[1][j], r[0][j]};
                s   = 4'(sbox_tab[nib]);
                for (int k = 0; k < 4; k++) r[k][j] = s[k];
            end
            n[0] = ((r[0] << 8) | (r[0] >> 24)) ^ r[1] ^ {27'd0, rc};
            n[1] = r[2];
            n[2] = ((r[2] << 16) | (r[2] >> 16)) ^ r[3];
            n[3] = r[0];
            for (int i = 0; i < 4; i++) r[i] = n[i];
            rc = {rc[3:0], rc[4] ^ rc[2]};
        end
    endtask

    task automatic load(input logic [127:0] mk);
        key   = mk;
        gen_model(mk);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Consume the stream; stop_at >= 0 abandons it after that many handshakes
    task automatic run_stream(input bit rand_ready, input int stop_at, input bit rev, input bit zero_k1);
        int          idx;
        int          n_hs;
        int          cyc;
        bit          rdy;
        logic [63:0] held;
        idx  = rev ? 25 : 0;
        n_hs = 0;
        cyc  = 0;
        while (n_hs < 26 && cyc < 400 && n_hs != stop_at) begin
            chk("valid", 64'(valid), 64'd1);
            chk("round", 64'(round), 64'(idx));
            chk("key", roundkey, exp_keys[idx]);
            chk("last", 64'(last), rev ? 64'(idx == 0) : 64'(idx == 25));
            if (zero_k1 && idx == 1) chk("k1_zero_key", roundkey, 64'h0000_0000_00FF_00FE);
            rdy   = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            ready = rdy;
            held  = roundkey;
            step();
            cyc++;
            if (rdy) begin
                n_hs++;
                idx = rev ? idx - 1 : idx + 1;
            end else begin
                chk("stall_hold", roundkey, held);
            end
        end
        ready = 1'b0;
        if (stop_at < 0) begin
            chk("hs_count", 64'(n_hs), 64'd26);
            if (!rand_ready) chk("cycles", 64'(cyc), 64'd26);
            chk("valid_after", 64'(valid), 64'd0);
            chk("busy_after", 64'(busy), 64'd0);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(valid), 64'd0);
        chk({tag, "_last"}, 64'(last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_round"}, 64'(round), 64'd0);
        chk({tag, "_key"}, roundkey, 64'd0);
    endtask

    initial begin
        logic [127:0] k2;
        rst_n  = 1'b0;
        start  = 1'b0;
        ready  = 1'b0;
        replay = 1'b0;
        key    = '0;
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_valid_before_start", 64'(valid), 64'd0);
        end
        ready = 1'b0;

        // Zero key, always ready: 26 back-to-back keys
        load(128'h0);
        run_stream(1'b0, -1, 1'b0, 1'b1);

        // Async reset in the middle of a run
        load({$urandom, $urandom, $urandom, $urandom});
        run_stream(1'b1, 3, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_idle("async_reset");
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        step();
        step();
        chk("no_valid_after_reset", 64'(valid), 64'd0);
        ready = 1'b0;

        // All-ones key, random back-pressure
        load({128{1'b1}});
        run_stream(1'b1, -1, 1'b0, 1'b0);

        // Restart at round 10 with a new key
        load({$urandom, $urandom, $urandom, $urandom});
        run_stream(1'b1, 10, 1'b0, 1'b0);
        chk("restart_pre_round", 64'(round), 64'd10);
        k2 = {$urandom, $urandom, $urandom, $urandom};
        load(k2);
        chk("restart_round", 64'(round), 64'd0);
        chk("restart_k0", roundkey, {k2[111:96], k2[79:64], k2[47:32], k2[15:0]});
        run_stream(1'b1, -1, 1'b0, 1'b0);

        // Start coinciding with a handshake: reload wins
        load({$urandom, $urandom, $urandom, $urandom});
        run_stream(1'b0, 5, 1'b0, 1'b0);
        k2 = {$urandom, $urandom, $urandom, $urandom};
        ready = 1'b1;
        load(k2);
        ready = 1'b0;
        chk("start_vs_hs_round", 64'(round), 64'd0);
        chk("start_vs_hs_k0", roundkey, {k2[111:96], k2[79:64], k2[47:32], k2[15:0]});
        run_stream(1'b1, -1, 1'b0, 1'b0);

`ifdef RECT_KEYBUF_EN
        replay = 1'b1;
        step();
        replay = 1'b0;
        run_stream(1'b1, -1, 1'b1, 1'b0);
`else
        replay = 1'b1;
        ready  = 1'b1;
        step();
        replay = 1'b0;
        step();
        chk("replay_ignored", 64'(valid), 64'd0);
        ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
